// File: rtl/ula_pkg.sv
// Shared opcode constants, opcode validity check and sequencer FSM states
// for the 8-bit ALU front end.
package ula_pkg;

    localparam logic [3:0] OP_SOMA  = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_RESTO = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_NAND  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1010;
    localparam logic [3:0] OP_NOT   = 4'b1011;

    typedef enum logic [1:0] {
        OCIOSO,
        EXECUTA,
        SAIDA
    } estado_t;

    // 0101 and 1100..1111 have no ALU operation behind them.
    function automatic logic op_invalido(input logic [3:0] sel);
        return (sel == 4'b0101) || (sel >= 4'b1100);
    endfunction

endpackage

// File: rtl/ula_fifo.sv
// Circular-buffer FIFO with occupancy count; no bypass, so a push into an
// empty FIFO is visible at the head only from the next cycle.
module ula_fifo #(
    parameter int LARGURA      = 20,
    parameter int PROFUNDIDADE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [LARGURA-1:0] dados_entrada,
    output logic [LARGURA-1:0] dados_saida,
    output logic               cheia,
    output logic               vazia
);

    localparam int PW = $clog2(PROFUNDIDADE);

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PW-1:0]      ptr_escrita;
    logic [PW-1:0]      ptr_leitura;
    logic [PW:0]        contagem;
    logic               push_ok;
    logic               pop_ok;

    assign push_ok     = push && !cheia;
    assign pop_ok      = pop && !vazia;
    assign cheia       = (contagem == (PW+1)'(PROFUNDIDADE));
    assign vazia       = (contagem == '0);
    assign dados_saida = mem[ptr_leitura];

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_escrita <= '0;
            ptr_leitura <= '0;
            contagem    <= '0;
        end else begin
            if (push_ok)
                ptr_escrita <= ptr_escrita + 1'b1;
            if (pop_ok)
                ptr_leitura <= ptr_leitura + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   contagem <= contagem + 1'b1;
                2'b01:   contagem <= contagem - 1'b1;
                default: contagem <= contagem;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[ptr_escrita] <= dados_entrada;
    end

endmodule

// File: rtl/ula_sequenciador.sv
// Buffers ALU operations, issues them one at a time and holds each result
// under a valid/ready handshake. Optional accumulator: ULA_SEQ_ACUMULADOR_EN.
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int PROFUNDIDADE = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Entrada_Valida,
    output logic        Entrada_Pronta,
    input  logic [7:0]  Op_A,
    input  logic [7:0]  Op_B,
    input  logic [3:0]  Op_Sel,
    input  logic        Op_Acc,
    output logic [7:0]  ULA_A,
    output logic [7:0]  ULA_B,
    output logic [3:0]  ULA_Sel,
    input  logic [15:0] ULA_Resultado,
    input  logic        ULA_Maior,
    input  logic        ULA_Menor,
    input  logic        ULA_Igual,
    output logic        Saida_Valida,
    input  logic        Saida_Pronta,
    output logic [15:0] Saida_Resultado,
    output logic        Saida_Maior,
    output logic        Saida_Menor,
    output logic        Saida_Igual,
    output logic        Saida_Erro
);

`ifdef ULA_SEQ_ACUMULADOR_EN
    localparam int LARGURA = 21;
`else
    localparam int LARGURA = 20;
`endif

    estado_t            estado;
    logic [LARGURA-1:0] entrada_fifo;
    logic [LARGURA-1:0] saida_fifo;
    logic               cheia;
    logic               vazia;
    logic               push;
    logic               pop;
    logic               transfere;
    logic               erro_atual;
    logic [7:0]         a_proximo;

    assign Entrada_Pronta = !cheia;
    assign push           = Entrada_Valida && !cheia;
    assign transfere      = Saida_Valida && Saida_Pronta;
    assign pop            = !vazia && ((estado == OCIOSO) || (estado == SAIDA && transfere));
    assign erro_atual     = op_invalido(ULA_Sel) ||
                            (((ULA_Sel == OP_DIV) || (ULA_Sel == OP_RESTO)) && (ULA_B == 8'h00));

`ifdef ULA_SEQ_ACUMULADOR_EN
    logic [7:0] acumulador;
    logic [7:0] acc_atual;

    assign entrada_fifo = {Op_Acc, Op_Sel, Op_B, Op_A};
    // A pop coinciding with an output transfer must see the value being loaded.
    assign acc_atual    = (transfere && !Saida_Erro) ? Saida_Resultado[7:0] : acumulador;
    assign a_proximo    = saida_fifo[20] ? acc_atual : saida_fifo[7:0];

    always_ff @(posedge Clk) begin
        if (Reset)
            acumulador <= 8'h00;
        else if (transfere && !Saida_Erro)
            acumulador <= Saida_Resultado[7:0];
    end
`else
    logic unused_acc;

    assign unused_acc   = Op_Acc;
    assign entrada_fifo = {Op_Sel, Op_B, Op_A};
    assign a_proximo    = saida_fifo[7:0];
`endif

    ula_fifo #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clk           (Clk),
        .reset         (Reset),
        .push          (push),
        .pop           (pop),
        .dados_entrada (entrada_fifo),
        .dados_saida   (saida_fifo),
        .cheia         (cheia),
        .vazia         (vazia)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado          <= OCIOSO;
            ULA_A           <= 8'h00;
            ULA_B           <= 8'h00;
            ULA_Sel         <= 4'h0;
            Saida_Valida    <= 1'b0;
            Saida_Resultado <= 16'h0000;
            Saida_Maior     <= 1'b0;
            Saida_Menor     <= 1'b0;
            Saida_Igual     <= 1'b0;
            Saida_Erro      <= 1'b0;
        end else begin
            if (pop) begin
                ULA_A   <= a_proximo;
                ULA_B   <= saida_fifo[15:8];
                ULA_Sel <= saida_fifo[19:16];
            end
            case (estado)
                OCIOSO: begin
                    if (!vazia)
                        estado <= EXECUTA;
                end
                EXECUTA: begin
                    Saida_Resultado <= erro_atual ? 16'h0000 : ULA_Resultado;
                    Saida_Maior     <= ULA_Maior;
                    Saida_Menor     <= ULA_Menor;
                    Saida_Igual     <= ULA_Igual;
                    Saida_Erro      <= erro_atual;
                    Saida_Valida    <= 1'b1;
                    estado          <= SAIDA;
                end
                SAIDA: begin
                    if (transfere) begin
                        Saida_Valida <= 1'b0;
                        estado       <= vazia ? OCIOSO : EXECUTA;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador with an attached ALU model and a result
// scoreboard; honours ULA_SEQ_ACUMULADOR_EN when defined.
module tb_ula_sequenciador;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Entrada_Valida;
    logic        Entrada_Pronta;
    logic [7:0]  Op_A, Op_B;
    logic [3:0]  Op_Sel;
    logic        Op_Acc;
    logic [7:0]  ULA_A, ULA_B;
    logic [3:0]  ULA_Sel;
    logic [15:0] ULA_Resultado;
    logic        ULA_Maior, ULA_Menor, ULA_Igual;
    logic        Saida_Valida;
    logic        Saida_Pronta;
    logic [15:0] Saida_Resultado;
    logic        Saida_Maior, Saida_Menor, Saida_Igual, Saida_Erro;

    typedef struct packed {
        logic [15:0] res;
        logic        maior;
        logic        menor;
        logic        igual;
        logic        erro;
    } esperado_t;

    esperado_t fila[$];
    int errors    = 0;
    int checks    = 0;
    int recebidos = 0;
    int r0;
`ifdef ULA_SEQ_ACUMULADOR_EN
    logic [7:0] acc_model = 8'h00;
`endif

    always #5 Clk = ~Clk;

    ula_sequenciador #(.PROFUNDIDADE(4)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Entrada_Valida  (Entrada_Valida),
        .Entrada_Pronta  (Entrada_Pronta),
        .Op_A            (Op_A),
        .Op_B            (Op_B),
        .Op_Sel          (Op_Sel),
        .Op_Acc          (Op_Acc),
        .ULA_A           (ULA_A),
        .ULA_B           (ULA_B),
        .ULA_Sel         (ULA_Sel),
        .ULA_Resultado   (ULA_Resultado),
        .ULA_Maior       (ULA_Maior),
        .ULA_Menor       (ULA_Menor),
        .ULA_Igual       (ULA_Igual),
        .Saida_Valida    (Saida_Valida),
        .Saida_Pronta    (Saida_Pronta),
        .Saida_Resultado (Saida_Resultado),
        .Saida_Maior     (Saida_Maior),
        .Saida_Menor     (Saida_Menor),
        .Saida_Igual     (Saida_Igual),
        .Saida_Erro      (Saida_Erro)
    );

    // ALU model; division by zero returns a garbage pattern on purpose.
    function automatic logic [15:0] alu_res(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        case (s)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return {8'h00, a} * {8'h00, b};
            4'd3:    return (b != 0) ? {8'h00, a / b} : 16'hFFFF;
            4'd4:    return (b != 0) ? {8'h00, a % b} : 16'hFFFF;
            4'd6:    return {8'h00, a & b};
            4'd7:    return {8'h00, a | b};
            4'd8:    return {8'h00, a ^ b};
            4'd9:    return {8'h00, ~(a & b)};
            4'd10:   return {8'h00, ~(a | b)};
            4'd11:   return {8'h00, ~a};
            default: return 16'hDEAD;
        endcase
    endfunction

    assign ULA_Resultado = alu_res(ULA_A, ULA_B, ULA_Sel);
    assign ULA_Maior     = (ULA_A > ULA_B);
    assign ULA_Menor     = (ULA_A < ULA_B);
    assign ULA_Igual     = (ULA_A == ULA_B);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enviar(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, input logic acc);
        esperado_t  e;
        logic [7:0] ae;
        logic       ok;
        Op_A = a; Op_B = b; Op_Sel = s; Op_Acc = acc;
        Entrada_Valida = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge Clk);
            ok = Entrada_Pronta;
            @(posedge Clk);
        end
        chk("aceite", {31'b0, ok}, 32'd1);
        if (ok) begin
`ifdef ULA_SEQ_ACUMULADOR_EN
            ae = acc ? acc_model : a;
`else
            ae = a;
`endif
            e.erro  = (s == 4'd5) || (s >= 4'd12) || (((s == 4'd3) || (s == 4'd4)) && (b == 8'd0));
            e.res   = e.erro ? 16'h0000 : alu_res(ae, b, s);
            e.maior = (ae > b);
            e.menor = (ae < b);
            e.igual = (ae == b);
            fila.push_back(e);
`ifdef ULA_SEQ_ACUMULADOR_EN
            if (!e.erro)
                acc_model = e.res[7:0];
`endif
        end
        #1 Entrada_Valida = 1'b0;
    endtask

    task automatic esvaziar();
        for (int i = 0; i < 300 && fila.size() != 0; i++)
            @(posedge Clk);
        chk("drenagem", fila.size(), 32'd0);
        repeat (3) @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        esperado_t e;
        if (!Reset && Saida_Valida && Saida_Pronta) begin
            recebidos++;
            if (fila.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL saida_inesperada: observed=%0h expected=none", Saida_Resultado);
            end else begin
                e = fila.pop_front();
                chk("resultado", {16'h0, Saida_Resultado}, {16'h0, e.res});
                chk("maior", {31'b0, Saida_Maior}, {31'b0, e.maior});
                chk("menor", {31'b0, Saida_Menor}, {31'b0, e.menor});
                chk("igual", {31'b0, Saida_Igual}, {31'b0, e.igual});
                chk("erro",  {31'b0, Saida_Erro},  {31'b0, e.erro});
            end
        end
    end

    initial begin
        Reset = 1'b1; Entrada_Valida = 1'b0; Saida_Pronta = 1'b0;
        Op_A = 8'h00; Op_B = 8'h00; Op_Sel = 4'h0; Op_Acc = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("rst_pronta", {31'b0, Entrada_Pronta}, 32'd1);
        chk("rst_valida", {31'b0, Saida_Valida}, 32'd0);
        chk("rst_ula", {12'h0, ULA_A, ULA_B, ULA_Sel}, 32'd0);
        chk("rst_saida", {11'h0, Saida_Resultado, Saida_Maior, Saida_Menor, Saida_Igual, Saida_Erro}, 32'd0);

        // Single op latency
        enviar(8'd5, 8'd3, 4'b0000, 1'b0);
        chk("lat_n_valida", {31'b0, Saida_Valida}, 32'd0);
        @(posedge Clk); #1;
        chk("lat_ula_a", {24'h0, ULA_A}, 32'd5);
        chk("lat_ula_b", {24'h0, ULA_B}, 32'd3);
        chk("lat_ula_sel", {28'h0, ULA_Sel}, 32'd0);
        chk("lat_n1_valida", {31'b0, Saida_Valida}, 32'd0);
        @(posedge Clk); #1;
        chk("lat_n2_valida", {31'b0, Saida_Valida}, 32'd1);
        chk("lat_resultado", {16'h0, Saida_Resultado}, 32'h0008);
        chk("lat_maior", {31'b0, Saida_Maior}, 32'd1);
        chk("lat_erro", {31'b0, Saida_Erro}, 32'd0);
        Saida_Pronta = 1'b1;
        esvaziar();

        // Error cases
        enviar(8'd9, 8'd0, 4'b0011, 1'b0);
        enviar(8'h21, 8'h07, 4'b0101, 1'b0);
        enviar(8'h40, 8'h02, 4'b1111, 1'b0);
        esvaziar();

        // Mixed back-to-back traffic
        enviar(8'd200, 8'd100, 4'd1, 1'b0);
        enviar(8'd100, 8'd200, 4'd1, 1'b0);
        enviar(8'd15, 8'd15, 4'd2, 1'b0);
        enviar(8'd200, 8'd7, 4'd3, 1'b0);
        enviar(8'd200, 8'd7, 4'd4, 1'b0);
        enviar(8'hF0, 8'h3C, 4'd6, 1'b0);
        enviar(8'hF0, 8'h3C, 4'd7, 1'b0);
        enviar(8'hF0, 8'h3C, 4'd8, 1'b0);
        enviar(8'hAA, 8'h0F, 4'd9, 1'b0);
        enviar(8'hAA, 8'h0F, 4'd10, 1'b0);
        enviar(8'h5A, 8'h00, 4'd11, 1'b0);
        enviar(8'd1, 8'd0, 4'd4, 1'b0);
        enviar(8'd3, 8'd4, 4'd12, 1'b0);
        esvaziar();

        // Full FIFO with a stalled consumer
        Saida_Pronta = 1'b0;
        for (int i = 0; i < 5; i++)
            enviar(8'(i * 3 + 1), 8'(i + 1), 4'd0, 1'b0);
        chk("cheia_pronta", {31'b0, Entrada_Pronta}, 32'd0);
        Op_A = 8'h77; Op_B = 8'h11; Op_Sel = 4'd0; Op_Acc = 1'b0;
        Entrada_Valida = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("sexta_recusada", {31'b0, Entrada_Pronta}, 32'd0);
        end
        Entrada_Valida = 1'b0;
        r0 = recebidos;
        Saida_Pronta = 1'b1;
        esvaziar();
        chk("cheia_sem_perda", recebidos - r0, 32'd5);

        // Accumulator chain, including a pop on the transfer edge
        enviar(8'd10, 8'd20, 4'd0, 1'b0);
        enviar(8'hFF, 8'd1, 4'd0, 1'b1);
        enviar(8'd1, 8'd0, 4'd3, 1'b0);
        enviar(8'd0, 8'd1, 4'd0, 1'b1);
        esvaziar();

        // Reset while holding a result with two queued entries
        Saida_Pronta = 1'b0;
        enviar(8'd1, 8'd2, 4'd0, 1'b0);
        enviar(8'd3, 8'd4, 4'd0, 1'b0);
        enviar(8'd5, 8'd6, 4'd0, 1'b0);
        chk("pre_rst_valida", {31'b0, Saida_Valida}, 32'd1);
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        fila.delete();
`ifdef ULA_SEQ_ACUMULADOR_EN
        acc_model = 8'h00;
`endif
        chk("rst_meio_valida", {31'b0, Saida_Valida}, 32'd0);
        chk("rst_meio_pronta", {31'b0, Entrada_Pronta}, 32'd1);
        Saida_Pronta = 1'b1;
        r0 = recebidos;
        repeat (10) @(posedge Clk);
        #1;
        chk("sem_resultado_antigo", recebidos - r0, 32'd0);
        enviar(8'd7, 8'd2, 4'd1, 1'b0);
        esvaziar();
        chk("pos_rst_um_resultado", recebidos - r0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
